// File: rtl/maxpool_2x2.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_2x2
//  Purpose  : 2x2, stride-2 signed max pooling over a raster-order pixel
//             stream read from an input FIFO. The pooled
//             (IMG_WIDTH/2) x (IMG_HEIGHT/2) raster stream goes to an output
//             FIFO. One line of horizontal pair maxima is buffered internally.
//  Ports    : clock          - rising-edge clock
//             reset          - asynchronous active-low reset (0 = in reset)
//             fifo_in_rd_en  - combinational read strobe to the input FIFO
//             fifo_in_dout   - signed pixel at the input FIFO head
//             fifo_in_empty  - input FIFO empty
//             fifo_out_wr_en - registered write strobe to the output FIFO
//             fifo_out_din   - registered signed pooled pixel
//             fifo_out_full  - output FIFO full
//  Revision : 1.0 - initial release
// ============================================================================
module maxpool_2x2 #(
   parameter int DWIDTH     = 16,
   parameter int IMG_WIDTH  = 720,
   parameter int IMG_HEIGHT = 540
) (
   input  logic              clock,
   input  logic              reset,
   output logic              fifo_in_rd_en,
   input  logic [DWIDTH-1:0] fifo_in_dout,
   input  logic              fifo_in_empty,
   output logic              fifo_out_wr_en,
   output logic [DWIDTH-1:0] fifo_out_din,
   input  logic              fifo_out_full
);

   localparam int COL_W    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LB_DEPTH = IMG_WIDTH / 2;
   localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      EVEN_A = 2'd0,
      EVEN_B = 2'd1,
      ODD_A  = 2'd2,
      ODD_B  = 2'd3
   } state_t;

   state_t                   state;
   logic [COL_W-1:0]         col;
   logic [ROW_W-1:0]         row;
   logic signed [DWIDTH-1:0] pair_hold;
   logic signed [DWIDTH-1:0] linebuf [LB_DEPTH];

   logic                     consume;
   logic                     end_of_line;
   logic signed [DWIDTH-1:0] din;
   logic signed [DWIDTH-1:0] pair_max;
   logic signed [DWIDTH-1:0] lb_rd;
   logic [LB_W-1:0]          lb_idx;

   function automatic logic signed [DWIDTH-1:0] smax(
      input logic signed [DWIDTH-1:0] a,
      input logic signed [DWIDTH-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   // A full output FIFO stalls every state, even rows included, so the
   // counters never run ahead of the output side.
   assign consume     = !fifo_in_empty && !fifo_out_full;
   assign fifo_in_rd_en = consume;

   assign din         = $signed(fifo_in_dout);
   assign end_of_line = (col == COL_LAST);
   // Each line-buffer entry holds the pair maximum of columns 2k and 2k+1.
   assign lb_idx      = LB_W'(col >> 1);
   assign pair_max    = smax(pair_hold, din);
   assign lb_rd       = linebuf[lb_idx];

   // Position counters and pooling FSM
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col            <= '0;
         row            <= '0;
         pair_hold      <= '0;
         state          <= EVEN_A;
         fifo_out_wr_en <= 1'b0;
         fifo_out_din   <= '0;
      end else begin
         // Strobe lasts exactly one cycle after an ODD_B consume.
         fifo_out_wr_en <= 1'b0;
         if (consume) begin
            if (end_of_line) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end

            case (state)
               EVEN_A: begin
                  pair_hold <= din;
                  state     <= EVEN_B;
               end
               EVEN_B: begin
                  state <= end_of_line ? ODD_A : EVEN_A;
               end
               ODD_A: begin
                  pair_hold <= din;
                  state     <= ODD_B;
               end
               ODD_B: begin
                  fifo_out_din   <= smax(pair_max, lb_rd);
                  fifo_out_wr_en <= 1'b1;
                  state          <= end_of_line ? EVEN_A : ODD_A;
               end
               default: state <= EVEN_A;
            endcase
         end
      end
   end

   // Line buffer: no reset, every entry is rewritten on each even row
   // before the following odd row reads it.
   always_ff @(posedge clock) begin
      if (consume && (state == EVEN_B)) begin
         linebuf[lb_idx] <= pair_max;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxpool_2x2
//  Purpose  : Self-checking bench for maxpool_2x2 (W=4, H=2). An input FIFO
//             is modelled as a queue; expected pooled values are computed
//             from whole frames with plain arithmetic, and strobe timing is
//             predicted from the raster position of each consumed pixel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_2x2;

   localparam int DW = 16;
   localparam int W  = 4;
   localparam int H  = 2;

   logic          clock;
   logic          reset;
   logic          fifo_in_rd_en;
   logic [DW-1:0] fifo_in_dout;
   logic          fifo_in_empty;
   logic          fifo_out_wr_en;
   logic [DW-1:0] fifo_out_din;
   logic          fifo_out_full;

   maxpool_2x2 #(
      .DWIDTH    (DW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .fifo_in_rd_en (fifo_in_rd_en),
      .fifo_in_dout  (fifo_in_dout),
      .fifo_in_empty (fifo_in_empty),
      .fifo_out_wr_en(fifo_out_wr_en),
      .fifo_out_din  (fifo_out_din),
      .fifo_out_full (fifo_out_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   int inq[$];      // input FIFO contents
   int exp_q[$];    // expected pooled outputs, in order
   int got[$];      // observed pooled outputs
   int fr[H][W];    // frame being assembled by the model
   int mcount    = 0;
   int nconsumed = 0;
   bit pending   = 0;   // a write is due in the next cycle
   bit force_empty = 0;
   bit force_full  = 0;
   bit rand_stall  = 0;

   task automatic check(input string tag, input longint actual, input longint required);
      n_checks++;
      if (actual != required) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, required, $time);
      end
   endtask

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic push_pix(input int v);
      inq.push_back(v);
      fr[mcount / W][mcount % W] = v;
      mcount++;
      if (mcount == W * H) begin
         mcount = 0;
         for (int r = 0; r < H; r += 2)
            for (int c = 0; c < W; c += 2)
               exp_q.push_back(max4(fr[r][c], fr[r][c+1], fr[r+1][c], fr[r+1][c+1]));
      end
   endtask

   task automatic push_frame(input int p0, input int p1, input int p2, input int p3,
                             input int p4, input int p5, input int p6, input int p7);
      push_pix(p0); push_pix(p1); push_pix(p2); push_pix(p3);
      push_pix(p4); push_pix(p5); push_pix(p6); push_pix(p7);
   endtask

   function automatic int gv(input int i);
      return (i < got.size()) ? got[i] : 99999;
   endfunction

   // One clock: check registered outputs, drive the next inputs, check the
   // combinational read strobe and account for the consume it implies.
   task automatic cycle();
      int r, c, e;
      @(negedge clock);
      check("wr_en", fifo_out_wr_en, pending);
      if (pending) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
         got.push_back(int'($signed(fifo_out_din)));
         check("din", $signed(fifo_out_din), e);
      end
      pending = 0;
      if (rand_stall) begin
         force_empty = ($urandom_range(0, 3) == 0);
         force_full  = ($urandom_range(0, 4) == 0);
      end
      fifo_in_empty = force_empty || (inq.size() == 0);
      fifo_out_full = force_full;
      fifo_in_dout  = (inq.size() > 0) ? DW'(inq[0]) : DW'($urandom);
      #1;
      check("rd_en", fifo_in_rd_en, !fifo_in_empty && !fifo_out_full);
      if (fifo_in_rd_en && inq.size() > 0) begin
         c = nconsumed % W;
         r = (nconsumed / W) % H;
         if ((r % 2 == 1) && (c % 2 == 1)) pending = 1;
         nconsumed++;
         void'(inq.pop_front());
      end
   endtask

   task automatic run_until(input int n, input int budget);
      int b = budget;
      while (nconsumed < n && b > 0) begin
         cycle();
         b--;
      end
      if (nconsumed < n) check("run_timeout", nconsumed, n);
   endtask

   task automatic drain(input int budget);
      int b = budget;
      while ((inq.size() > 0 || pending) && b > 0) begin
         cycle();
         b--;
      end
      check("drain_left", inq.size(), 0);
   endtask

   task automatic flush_model();
      inq.delete();
      exp_q.delete();
      got.delete();
      mcount    = 0;
      nconsumed = 0;
      pending   = 0;
   endtask

   initial begin
      reset         = 1'b0;
      fifo_in_empty = 1'b1;
      fifo_out_full = 1'b0;
      fifo_in_dout  = '0;
      #12;
      check("rst_wr_en", fifo_out_wr_en, 0);
      check("rst_din", fifo_out_din, 0);
      check("rst_rd_en", fifo_in_rd_en, 0);
      @(negedge clock);
      reset = 1'b1;

      // 1: basic frame
      flush_model();
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      drain(50);
      check("t1_n", got.size(), 2);
      check("t1_o0", gv(0), 5);
      check("t1_o1", gv(1), 7);

      // 2: back-to-back frames
      got.delete();
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      drain(50);
      check("t2_n", got.size(), 4);
      check("t2_o0", gv(0), 5);
      check("t2_o1", gv(1), 7);
      check("t2_o2", gv(2), 5);
      check("t2_o3", gv(3), 7);

      // 3: all-negative frame
      got.delete();
      push_frame(-8, -3, -9, -1, -7, -4, -2, -6);
      drain(50);
      check("t3_o0", gv(0), -3);
      check("t3_o1", gv(1), -1);

      // 4: input empty for 5 cycles after the 2nd pixel
      got.delete();
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      run_until(nconsumed + 2, 50);
      force_empty = 1;
      repeat (5) cycle();
      force_empty = 0;
      drain(50);
      check("t4_o0", gv(0), 5);
      check("t4_o1", gv(1), 7);

      // 5: output full for 10 cycles from the 3rd pixel
      got.delete();
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      run_until(nconsumed + 2, 50);
      force_full = 1;
      repeat (10) cycle();
      force_full = 0;
      drain(50);
      check("t5_o0", gv(0), 5);
      check("t5_o1", gv(1), 7);

      // 6: async reset after 5 pixels, then a fresh frame
      flush_model();
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      run_until(5, 50);
      @(posedge clock);
      #2;
      fifo_in_empty = 1'b1;
      reset = 1'b0;
      #1;
      check("t6_wr_en", fifo_out_wr_en, 0);
      check("t6_din", fifo_out_din, 0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      flush_model();
      push_frame(1, 5, -3, 2, 4, 0, 7, -8);
      drain(50);
      check("t6_n", got.size(), 2);
      check("t6_o0", gv(0), 5);
      check("t6_o1", gv(1), 7);

      // 7: random frames with random stalls
      got.delete();
      for (int f = 0; f < 40; f++)
         for (int k = 0; k < W * H; k++) begin
            logic signed [DW-1:0] v;
            v = DW'($urandom);
            push_pix(int'(v));
         end
      rand_stall = 1;
      drain(3000);
      rand_stall  = 0;
      force_empty = 0;
      force_full  = 0;
      drain(20);
      check("t7_n", got.size(), 80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Downstream neighbour of the ReLU stage in the sobel_v2 pipeline.
- Consumes a raster-order stream of signed pixels from a FIFO and performs 2x2, stride-2 max pooling.
- Writes a (IMG_WIDTH/2) x (IMG_HEIGHT/2) raster-order stream to an output FIFO.
- Buffers one line of horizontal pair maxima internally, so no external line storage is needed.

Parameters:
- DWIDTH, 16, pixel width in bits, two's complement.
- IMG_WIDTH, 720, input pixels per line; must be even and >= 2.
- IMG_HEIGHT, 540, input lines per frame; must be even and >= 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- fifo_in_rd_en  output  1  combinational read strobe to the input FIFO.
- fifo_in_dout  input  DWIDTH  signed pixel at the input FIFO head; valid when fifo_in_empty=0.
- fifo_in_empty  input  1  input FIFO empty.
- fifo_out_wr_en  output  1  registered write strobe to the output FIFO.
- fifo_out_din  output  DWIDTH  registered signed pooled pixel.
- fifo_out_full  input  1  output FIFO full.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. While reset=0:
  - fifo_out_wr_en=0, fifo_out_din=0.
  - col=0, row=0, pair_hold=0, state=EVEN_A.
  - Line buffer contents are don't-care; every entry is rewritten on each even row before it is read.
- Consume rule: fifo_in_rd_en = !fifo_in_empty && !fifo_out_full, combinational.
  - Applies in every state, including even rows; a full output FIFO stalls the whole stage.
  - A pixel counts as consumed exactly in a cycle where fifo_in_rd_en=1; fifo_in_dout is sampled in that cycle.
- Counters: col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, advancing only on consume.
  - col wraps to 0 and increments row.
  - row wraps to 0 after the last pixel of a frame; back-to-back frames need no gap.
- Pooling FSM (state advances only on consume):
  - EVEN_A (row even, col even): pair_hold <= din. Next state EVEN_B.
  - EVEN_B (row even, col odd): linebuf[col>>1] <= smax(pair_hold, din). Next state EVEN_A, or ODD_A at end of line.
  - ODD_A (row odd, col even): pair_hold <= din. Next state ODD_B.
  - ODD_B (row odd, col odd): fifo_out_din <= smax(smax(pair_hold, din), linebuf[col>>1]) and fifo_out_wr_en <= 1. Next state ODD_A, or EVEN_A at end of line (including frame wrap).
- Output strobe: fifo_out_wr_en is 1 for exactly the cycle after each ODD_B consume and 0 in every other cycle.
  - fifo_out_din holds its last value when no write occurs.
- Arithmetic:
  - smax is a signed comparison; ties select either operand, since the result is identical.
  - No widening and no saturation; the output width is DWIDTH.
  - Negative inputs are legal and are compared correctly.
- Latency: one clock from the consume of the bottom-right pixel of a 2x2 window to fifo_out_wr_en=1.
- Throughput: one input pixel per clock when unstalled; one output per four inputs.
- Line buffer: IMG_WIDTH/2 entries of DWIDTH bits.
  - Single write port, written in EVEN_B; single read port, read in ODD_B.
  - May be implemented as registers or as inferred RAM with combinational read.
  - If RAM with registered read is used, the read address is issued in ODD_A so that the ODD_B timing above is unchanged.
- Boundary conditions:
  - fifo_in_empty=1 mid-window: state, counters and pair_hold are held; no output.
  - fifo_out_full=1 in any state: no consume. A write already registered in the previous cycle still completes; the FIFO's full flag accounts for it through almost-full margin owned by the FIFO.
  - fifo_in_empty and fifo_out_full both 1: idle.
  - Reset asserted mid-frame: the partial frame is discarded. After release, the next consumed pixel is treated as row 0, col 0.
  - The block never asserts fifo_in_rd_en while fifo_in_empty=1, and never asserts fifo_out_wr_en from a cycle where fifo_out_full was sampled 1 at consume.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=2; stream 1,5,-3,2 / 4,0,7,-8 with no stalls -> exactly two writes, din=5 then din=7. First write occurs one cycle after the 6th consume (pixel 0), second write one cycle after the 8th consume (pixel -8).
2. Same frame sent twice back-to-back -> outputs 5,7,5,7. Counters wrap with no idle cycle; confirms frame wrap.
3. All-negative frame -8,-3,-9,-1 / -7,-4,-2,-6 (W=4, H=2) -> outputs -3, -1; confirms signed compare.
4. Hold fifo_in_empty=1 for 5 cycles between the 2nd and 3rd pixels of test 1 -> identical outputs 5,7; no rd_en while empty; fifo_out_wr_en never glitches.
5. Assert fifo_out_full=1 for 10 cycles starting at the 3rd pixel -> fifo_in_rd_en=0 throughout; after release, outputs 5,7 with one-cycle latency preserved.
6. Drive reset=0 asynchronously after 5 pixels of test 1, release, then send a full fresh frame -> wr_en and din go to 0 immediately without a clock edge; only the fresh frame's outputs 5,7 appear.
